// File: rtl/tri_transform.sv
// tri_transform: vertex transform stage. Multiplies the three vertices of a
// triangle by a 4x4 signed Q16.16 matrix with one time-shared multiplier
// (48 MACs), then presents the transformed triangle on a valid/ready port.
module tri_transform #(
   parameter int NUM_VERTS = 3,
   parameter int FRAC_BITS = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [3:0][31:0] v1_in,
   input  logic [3:0][31:0] v2_in,
   input  logic [3:0][31:0] v3_in,
   input  logic             valid_in,
   input  logic             last_in,
   output logic             ready_out,
   input  logic             mat_we,
   input  logic [3:0]       mat_addr,
   input  logic [31:0]      mat_data,
   output logic [3:0][31:0] v1_out,
   output logic [3:0][31:0] v2_out,
   output logic [3:0][31:0] v3_out,
   output logic             valid_out,
   output logic             last_out,
   input  logic             ready_in
);

   localparam int          MAC_LAST = NUM_VERTS * 16 - 1;
   localparam logic [31:0] Q_ONE    = 32'h0001_0000;

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

   state_t                         state, state_nxt;
   logic [5:0]                     cnt;       // {vertex, row, col}
   logic [15:0][31:0]              stg_mat;
   logic [15:0][31:0]              act_mat;
   logic                           first_tri;
   logic                           last_q;
   logic [NUM_VERTS-1:0][2:0][31:0] vtx_q;    // [v][0]=x, [1]=y, [2]=z
   logic [NUM_VERTS-1:0][3:0][31:0] res_q;
   logic signed [63:0]             mul_a, mul_b, prod_q, acc_q, acc_nxt;
   logic [31:0]                    op_b;
   logic [5:0]                     prod_idx;
   logic [1:0]                     vld_pipe;  // [0] product valid, [1] triangle done
   logic                           accept;
   logic                           unused_w;

   // Input w lanes are replaced by 1.0 and never read.
   assign unused_w = ^{v1_in[0], v2_in[0], v3_in[0]};

   assign accept = (state == IDLE) && valid_in;

   function automatic logic [15:0][31:0] ident();
      logic [15:0][31:0] m;
      for (int i = 0; i < 16; i++) m[i] = (i % 5 == 0) ? Q_ONE : 32'h0;
      return m;
   endfunction

   // State register
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid_in) state_nxt = MAC;
         MAC:     if (cnt == 6'(MAC_LAST)) state_nxt = DRAIN;
         DRAIN:   state_nxt = OUT;
         OUT:     if (valid_out && ready_in) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ready_out = (state == IDLE);
   end

   // Staging matrix: written any cycle, independent of the datapath
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)     stg_mat           <= ident();
      else if (mat_we) stg_mat[mat_addr] <= mat_data;
   end

   // Triangle capture; active matrix reloads only on an object's first triangle
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         act_mat   <= ident();
         first_tri <= 1'b1;
         last_q    <= 1'b0;
         vtx_q     <= '0;
      end else if (accept) begin
         if (first_tri) act_mat <= stg_mat;
         first_tri <= last_in;
         last_q    <= last_in;
         vtx_q[0]  <= {v1_in[1], v1_in[2], v1_in[3]};
         vtx_q[1]  <= {v2_in[1], v2_in[2], v2_in[3]};
         vtx_q[2]  <= {v3_in[1], v3_in[2], v3_in[3]};
      end
   end

   // MAC step counter
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)             cnt <= '0;
      else if (accept)         cnt <= '0;
      else if (state == MAC)   cnt <= cnt + 6'd1;
   end

   // Multiplier operands: cnt[3:0] is row*4+col, column 3 multiplies w = 1.0
   always_comb begin
      op_b  = (cnt[1:0] == 2'd3) ? Q_ONE : vtx_q[cnt[5:4]][cnt[1:0]];
      mul_a = {{32{act_mat[cnt[3:0]][31]}}, act_mat[cnt[3:0]]};
      mul_b = {{32{op_b[31]}}, op_b};
   end

   // Registered product stage plus done flag for the final product
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         prod_q   <= '0;
         prod_idx <= '0;
         vld_pipe <= '0;
      end else begin
         prod_q      <= mul_a * mul_b;
         prod_idx    <= cnt;
         vld_pipe[0] <= (state == MAC);
         vld_pipe[1] <= vld_pipe[0] && (prod_idx == 6'(MAC_LAST));
      end
   end

   // Accumulator restarts at column 0 of each row
   always_comb begin
      acc_nxt = ((prod_idx[1:0] == 2'd0) ? 64'sd0 : acc_q) + prod_q;
   end

   // Accumulate; on column 3 store the floor-truncated row result (row r -> lane 3-r)
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         acc_q <= '0;
         res_q <= '0;
      end else if (vld_pipe[0]) begin
         acc_q <= acc_nxt;
         if (prod_idx[1:0] == 2'd3)
            res_q[prod_idx[5:4]][~prod_idx[3:2]] <= acc_nxt[FRAC_BITS +: 32];
      end
   end

   // Output register: loaded once per triangle, held until transfer
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         v1_out    <= '0;
         v2_out    <= '0;
         v3_out    <= '0;
         valid_out <= 1'b0;
         last_out  <= 1'b0;
      end else if (vld_pipe[1]) begin
         v1_out    <= res_q[0];
         v2_out    <= res_q[1];
         v3_out    <= res_q[2];
         valid_out <= 1'b1;
         last_out  <= last_q;
      end else if (valid_out && ready_in) begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tri_transform.sv
// tb_tri_transform: directed vector table plus hand sequences for
// backpressure, matrix latch timing and reset during operation.
module tb_tri_transform;

   localparam logic [31:0] ONE = 32'h0001_0000;

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b0;
   logic [3:0][31:0] v1_in = '0, v2_in = '0, v3_in = '0;
   logic             valid_in = 1'b0, last_in = 1'b0;
   logic             ready_out;
   logic             mat_we = 1'b0;
   logic [3:0]       mat_addr = '0;
   logic [31:0]      mat_data = '0;
   logic [3:0][31:0] v1_out, v2_out, v3_out;
   logic             valid_out, last_out;
   logic             ready_in = 1'b1;

   int total = 0;
   int bad   = 0;

   tri_transform dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .v1_in(v1_in), .v2_in(v2_in), .v3_in(v3_in),
      .valid_in(valid_in), .last_in(last_in), .ready_out(ready_out),
      .mat_we(mat_we), .mat_addr(mat_addr), .mat_data(mat_data),
      .v1_out(v1_out), .v2_out(v2_out), .v3_out(v3_out),
      .valid_out(valid_out), .last_out(last_out), .ready_in(ready_in)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int               mset;   // preset written to staging before the triangle, -1 none
      logic [3:0][31:0] v1, v2, v3;
      logic             last;
      logic [3:0][31:0] e1, e2, e3;
   } vec_t;

   function automatic logic [31:0] q(input int n);
      logic [31:0] t;
      t = n;
      return t << 16;
   endfunction

   // Input vertex; w carries junk that must be ignored
   function automatic logic [3:0][31:0] vi(input logic [31:0] x, y, z);
      return {x, y, z, 32'hDEAD_BEEF};
   endfunction

   function automatic logic [3:0][31:0] vo(input logic [31:0] x, y, z);
      return {x, y, z, ONE};
   endfunction

   // 0 identity, 1 translate (+5,-2,0), 2 scale xyz by 2, 3 wrap/floor probe
   function automatic logic [31:0] preset(input int k, input int i);
      logic [31:0] v;
      v = (i % 5 == 0) ? ONE : 32'h0;
      case (k)
         1: begin if (i == 3) v = q(5); if (i == 7) v = q(-2); end
         2: if (i == 0 || i == 5 || i == 10) v = q(2);
         3: begin if (i == 0) v = 32'h7FFF_0000; if (i == 5) v = 32'hFFFF_8000; end
         default: ;
      endcase
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      mat_we = 1'b1; mat_addr = 4'(a); mat_data = d;
      @(negedge clk_in);
      mat_we = 1'b0;
   endtask

   task automatic load_preset(input int k);
      for (int i = 0; i < 16; i++) wr(i, preset(k, i));
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic send(input logic [3:0][31:0] a, b, c, input logic l,
                       input logic we, input logic [3:0] ad, input logic [31:0] d);
      int n = 0;
      while (!ready_out && n < 200) begin @(negedge clk_in); n++; end
      if (n >= 200) chk("ready_timeout", 128'(ready_out), 128'd1);
      v1_in = a; v2_in = b; v3_in = c; last_in = l; valid_in = 1'b1;
      mat_we = we; mat_addr = ad; mat_data = d;
      @(negedge clk_in);
      valid_in = 1'b0; last_in = 1'b0; mat_we = 1'b0;
   endtask

   task automatic collect(input string nm, input logic [3:0][31:0] e1, e2, e3,
                          input logic el, input int hold);
      int lat = 0;
      int changes = 0;
      logic [385:0] snap;
      ready_in = (hold == 0);
      while (!valid_out && lat < 100) begin @(negedge clk_in); lat++; end
      chk({nm, ".latency"}, 128'(lat), 128'd50);
      chk({nm, ".v1"}, v1_out, e1);
      chk({nm, ".v2"}, v2_out, e2);
      chk({nm, ".v3"}, v3_out, e3);
      chk({nm, ".last"}, 128'(last_out), 128'(el));
      if (hold > 0) begin
         snap = {v1_out, v2_out, v3_out, valid_out, last_out};
         for (int i = 0; i < hold; i++) begin
            @(negedge clk_in);
            if ({v1_out, v2_out, v3_out, valid_out, last_out} !== snap) changes++;
            if (ready_out) changes++;
         end
         chk({nm, ".hold_changes"}, 128'(changes), 128'd0);
         ready_in = 1'b1;
      end
      @(negedge clk_in);
      chk({nm, ".post_xfer_rdy_vld"}, {ready_out, valid_out}, 128'b10);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{-1, vi(q(1), q(2), q(3)), vi(q(-1), 0, 32'h8000), vi(0, 0, 0), 1'b1,
                  vo(q(1), q(2), q(3)), vo(q(-1), 0, 32'h8000), vo(0, 0, 0)};
      vecs[1] = '{1, vi(q(1), q(1), q(1)), vi(0, 0, 0), vi(q(2), q(3), q(4)), 1'b1,
                  vo(q(6), q(-1), q(1)), vo(q(5), q(-2), 0), vo(q(7), q(1), q(4))};
      vecs[2] = '{-1, vi(0, 0, 0), vi(q(-5), q(2), 0), vi(q(1), q(2), q(3)), 1'b0,
                  vo(q(5), q(-2), 0), vo(0, 0, 0), vo(q(6), 0, q(3))};
      // scale written mid-object: this triangle still sees the translation
      vecs[3] = '{2, vi(q(1), q(2), q(3)), vi(0, 0, q(7)), vi(q(-1), q(-1), q(-1)), 1'b1,
                  vo(q(6), 0, q(3)), vo(q(5), q(-2), q(7)), vo(q(4), q(-3), q(-1))};
      vecs[4] = '{-1, vi(q(1), q(2), q(3)), vi(q(-1), 0, 32'h8000), vi(32'h4000, 0, 0), 1'b1,
                  vo(q(2), q(4), q(6)), vo(q(-2), 0, q(1)), vo(32'h8000, 0, 0)};
      vecs[5] = '{3, vi(q(2), 32'h1, 0), vi(q(1), 0, 0), vi(0, q(-1), 0), 1'b1,
                  vo(32'hFFFE_0000, 32'hFFFF_FFFF, 0), vo(32'h7FFF_0000, 0, 0),
                  vo(0, 32'h0000_8000, 0)};
      vecs[6] = '{0, vi(q(3), q(-4), 32'h4000), vi(0, 0, 0), vi(q(-7), q(8), q(-9)), 1'b1,
                  vo(q(3), q(-4), 32'h4000), vo(0, 0, 0), vo(q(-7), q(8), q(-9))};

      // Reset state
      repeat (3) @(negedge clk_in);
      chk("rst.vld_last", {valid_out, last_out}, 128'b00);
      chk("rst.v1", v1_out, 128'd0);
      chk("rst.v3", v3_out, 128'd0);
      rst_in = 1'b1;
      @(negedge clk_in);
      chk("rst.ready", 128'(ready_out), 128'd1);

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].mset >= 0) load_preset(vecs[i].mset);
         send(vecs[i].v1, vecs[i].v2, vecs[i].v3, vecs[i].last, 1'b0, 4'd0, 32'd0);
         collect($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].last, 0);
      end

      // Backpressure: hold OUT for 20 cycles
      send(vi(q(1), q(2), q(3)), vi(0, q(1), 0), vi(0, 0, 0), 1'b0, 1'b0, 4'd0, 32'd0);
      collect("bp", vo(q(1), q(2), q(3)), vo(0, q(1), 0), vo(0, 0, 0), 1'b0, 20);
      // finish that object so the next triangle latches the staging matrix
      send(vi(0, 0, 0), vi(0, 0, 0), vi(0, 0, 0), 1'b1, 1'b0, 4'd0, 32'd0);
      collect("bp_end", vo(0, 0, 0), vo(0, 0, 0), vo(0, 0, 0), 1'b1, 0);

      // Staging write on the same edge as the latch: old contents win
      send(vi(q(1), 0, 0), vi(0, 0, 0), vi(0, 0, 0), 1'b1, 1'b1, 4'd0, q(3));
      collect("samewr0", vo(q(1), 0, 0), vo(0, 0, 0), vo(0, 0, 0), 1'b1, 0);
      send(vi(q(1), 0, 0), vi(0, 0, 0), vi(0, 0, 0), 1'b1, 1'b0, 4'd0, 32'd0);
      collect("samewr1", vo(q(3), 0, 0), vo(0, 0, 0), vo(0, 0, 0), 1'b1, 0);

      // Reset 10 cycles into MAC with a non-identity matrix in both banks
      load_preset(2);
      send(vi(q(1), q(2), q(3)), vi(0, 0, 0), vi(0, 0, 0), 1'b1, 1'b0, 4'd0, 32'd0);
      collect("prerst", vo(q(2), q(4), q(6)), vo(0, 0, 0), vo(0, 0, 0), 1'b1, 0);
      send(vi(q(1), q(1), q(1)), vi(0, 0, 0), vi(0, 0, 0), 1'b0, 1'b0, 4'd0, 32'd0);
      repeat (10) @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      chk("macrst.rdy_vld", {ready_out, valid_out}, 128'b10);
      begin
         int seen = 0;
         for (int i = 0; i < 60; i++) begin
            @(negedge clk_in);
            if (valid_out) seen++;
         end
         chk("macrst.dropped", 128'(seen), 128'd0);
      end
      send(vi(q(1), q(2), q(3)), vi(q(-1), 0, 0), vi(0, 0, 0), 1'b1, 1'b0, 4'd0, 32'd0);
      collect("postrst", vo(q(1), q(2), q(3)), vo(q(-1), 0, 0), vo(0, 0, 0), 1'b1, 0);

      // Reset while held in OUT: valid_out drops without a clock edge
      ready_in = 1'b0;
      send(vi(q(1), 0, 0), vi(0, 0, 0), vi(0, 0, 0), 1'b1, 1'b0, 4'd0, 32'd0);
      begin
         int n = 0;
         while (!valid_out && n < 100) begin @(negedge clk_in); n++; end
         chk("outrst.reached", 128'(valid_out), 128'd1);
      end
      #2 rst_in = 1'b0;
      #1 chk("outrst.async", {valid_out, last_out, v1_out}, 128'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      ready_in = 1'b1;
      @(negedge clk_in);
      chk("outrst.rdy_vld", {ready_out, valid_out}, 128'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
